// File: rtl/alu_pkg.sv
// Shared encodings for the ALU/register-file slice: opcodes, extended opcodes,
// flag bit positions and the internal function select used by alu_core.
package alu_pkg;

  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_LWI   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_ADDU  = 4'b0110;
  localparam logic [3:0] OP_ADDC  = 4'b0111;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_ADDCU = 4'b1101;

  localparam logic [3:0] EX_NOP   = 4'b0000;
  localparam logic [3:0] EX_AND   = 4'b0001;
  localparam logic [3:0] EX_OR    = 4'b0010;
  localparam logic [3:0] EX_XOR   = 4'b0011;
  localparam logic [3:0] EX_ADD   = 4'b0101;
  localparam logic [3:0] EX_ADDU  = 4'b0110;
  localparam logic [3:0] EX_ADDC  = 4'b0111;
  localparam logic [3:0] EX_SUB   = 4'b1001;
  localparam logic [3:0] EX_CMP   = 4'b1011;
  localparam logic [3:0] EX_MOV   = 4'b1101;

  localparam logic [3:0] EX_ARSH  = 4'b0011;
  localparam logic [3:0] EX_LSH   = 4'b0100;
  localparam logic [3:0] EX_RSH   = 4'b0101;
  localparam logic [3:0] EX_ALSH  = 4'b0110;
  localparam logic [3:0] EX_RSHI  = 4'b0111;
  localparam logic [3:0] EX_LSHI  = 4'b1000;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [3:0] {
    FN_NOP, FN_AND, FN_OR, FN_XOR, FN_ADD, FN_SUB, FN_CMP,
    FN_PASSB, FN_SHL, FN_SHR, FN_ASR
  } aluFn_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: decodes op/exop, produces the 16-bit result and {C,L,F,Z,N}.
// Zero latency; resultVld/flagsVld tell the caller whether to write each.
module alu_core
  import alu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic [3:0]  op,
  input  logic [3:0]  exop,
  output logic [15:0] result,
  output logic [4:0]  flags,
  output logic        resultVld,
  output logic        flagsVld
);

  aluFn_e      fn;
  logic        addCin;
  logic [16:0] sum17;
  logic [16:0] diff17;
  logic        addOvf;
  logic        subOvf;
  logic        ltU;
  logic        ltS;
  logic [3:0]  shamt;
  logic [15:0] asrVal;

  always_comb begin
    fn     = FN_NOP;
    addCin = 1'b0;
    unique case (op)
      OP_AND:   fn = FN_AND;
      OP_LWI:   fn = FN_PASSB;
      OP_ADD, OP_ADDU: fn = FN_ADD;
      OP_ADDC, OP_ADDCU: begin
        fn     = FN_ADD;
        addCin = 1'b1;
      end
      OP_SUB:   fn = FN_SUB;
      OP_CMP:   fn = FN_CMP;
      OP_REG: begin
        unique case (exop)
          EX_AND:  fn = FN_AND;
          EX_OR:   fn = FN_OR;
          EX_XOR:  fn = FN_XOR;
          EX_ADD, EX_ADDU: fn = FN_ADD;
          EX_ADDC: begin
            fn     = FN_ADD;
            addCin = 1'b1;
          end
          EX_SUB:  fn = FN_SUB;
          EX_CMP:  fn = FN_CMP;
          EX_MOV:  fn = FN_PASSB;
          default: fn = FN_NOP;
        endcase
      end
      OP_SHIFT: begin
        unique case (exop)
          EX_LSH, EX_LSHI, EX_ALSH: fn = FN_SHL;
          EX_RSH, EX_RSHI:          fn = FN_SHR;
          EX_ARSH:                  fn = FN_ASR;
          default:                  fn = FN_NOP;
        endcase
      end
      default: fn = FN_NOP;
    endcase
  end

  // Carry-in only participates for the ADDC family; 17 bits keep the carry/borrow.
  assign sum17  = {1'b0, a} + {1'b0, b} + {16'b0, cin & addCin};
  assign diff17 = {1'b0, a} - {1'b0, b};
  assign addOvf = (a[15] == b[15]) && (sum17[15] != a[15]);
  assign subOvf = (a[15] != b[15]) && (diff17[15] != a[15]);
  assign ltU    = a < b;
  assign ltS    = $signed(a) < $signed(b);
  assign shamt  = b[3:0];
  assign asrVal = $signed(a) >>> shamt;

  always_comb begin
    result    = 16'h0000;
    flags     = 5'b00000;
    resultVld = 1'b1;
    flagsVld  = 1'b0;
    unique case (fn)
      FN_AND:   result = a & b;
      FN_OR:    result = a | b;
      FN_XOR:   result = a ^ b;
      FN_PASSB: result = b;
      FN_SHL:   result = a << shamt;
      FN_SHR:   result = a >> shamt;
      FN_ASR:   result = asrVal;
      FN_ADD: begin
        result         = sum17[15:0];
        flagsVld       = 1'b1;
        flags[FLAG_C]  = sum17[16];
        flags[FLAG_L]  = ltU;
        flags[FLAG_F]  = addOvf;
        flags[FLAG_Z]  = (sum17[15:0] == 16'h0000);
        flags[FLAG_N]  = ltS;
      end
      FN_SUB, FN_CMP: begin
        result         = (fn == FN_CMP) ? {15'b0, ltS} : diff17[15:0];
        flagsVld       = 1'b1;
        flags[FLAG_C]  = diff17[16];
        flags[FLAG_L]  = ltU;
        flags[FLAG_F]  = subOvf;
        flags[FLAG_Z]  = (diff17[15:0] == 16'h0000);
        flags[FLAG_N]  = ltS;
      end
      default:  resultVld = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_reg_integration.sv
// Sixteen 16-bit registers around alu_core; result and flags commit one edge after inputs.
// Destinations 16-31 discard the result; flags hold unless an add/sub/cmp executes.
module alu_reg_integration
  import alu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] immediate,
  input  logic [4:0]  regEnables,
  input  logic [4:0]  buffAEnables,
  input  logic [4:0]  buffBEnables,
  input  logic        Cin,
  input  logic        regOrImmed,
  input  logic [3:0]  op,
  input  logic [3:0]  exop,
  output logic [4:0]  flagsOutput,
  output logic [15:0] regOut15
);

  logic [15:0] regs [16];
  logic [15:0] aVal;
  logic [15:0] bVal;
  logic [15:0] aluResult;
  logic [4:0]  aluFlags;
  logic        resultVld;
  logic        flagsVld;
  logic        writeEn;
  logic        unusedSelBits;

  assign unusedSelBits = buffAEnables[4] ^ buffBEnables[4];

  assign aVal = regs[buffAEnables[3:0]];
  assign bVal = regOrImmed ? regs[buffBEnables[3:0]] : immediate;

  alu_core uAluCore (
    .a         (aVal),
    .b         (bVal),
    .cin       (Cin),
    .op        (op),
    .exop      (exop),
    .result    (aluResult),
    .flags     (aluFlags),
    .resultVld (resultVld),
    .flagsVld  (flagsVld)
  );

  assign writeEn = resultVld && !regEnables[4];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
      flagsOutput <= 5'b00000;
    end else begin
      if (writeEn) regs[regEnables[3:0]] <= aluResult;
      if (flagsVld) flagsOutput <= aluFlags;
    end
  end

  assign regOut15 = regs[15];

endmodule

// File: tb/tb_alu_reg_integration.sv
// Directed-vector bench for alu_reg_integration: expected values are hand-computed
// from the operation definitions and compared against R15 and the flag register.
module tb_alu_reg_integration;

  logic        clock;
  logic        reset;
  logic [15:0] immediate;
  logic [4:0]  regEnables;
  logic [4:0]  buffAEnables;
  logic [4:0]  buffBEnables;
  logic        Cin;
  logic        regOrImmed;
  logic [3:0]  op;
  logic [3:0]  exop;
  logic [4:0]  flagsOutput;
  logic [15:0] regOut15;

  int checkCount = 0;
  int passCount  = 0;

  alu_reg_integration dut (
    .clock        (clock),
    .reset        (reset),
    .immediate    (immediate),
    .regEnables   (regEnables),
    .buffAEnables (buffAEnables),
    .buffBEnables (buffBEnables),
    .Cin          (Cin),
    .regOrImmed   (regOrImmed),
    .op           (op),
    .exop         (exop),
    .flagsOutput  (flagsOutput),
    .regOut15     (regOut15)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  // Apply one instruction, clock it, and return 1 time unit after the edge.
  task automatic runOp(input logic [3:0] o, input logic [3:0] ex, input logic [4:0] dst,
                       input logic [4:0] srcA, input logic [4:0] srcB, input logic rOrI,
                       input logic [15:0] imm, input logic c);
    op           = o;
    exop         = ex;
    regEnables   = dst;
    buffAEnables = srcA;
    buffBEnables = srcB;
    regOrImmed   = rOrI;
    immediate    = imm;
    Cin          = c;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    immediate = '0; regEnables = 5'd31; buffAEnables = '0; buffBEnables = '0;
    Cin = 1'b0; regOrImmed = 1'b0; op = '0; exop = '0;

    repeat (2) @(posedge clock);
    #1;
    checkEq("reset_r15", regOut15, 16'h0000);
    checkEq("reset_flags", {11'b0, flagsOutput}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;

    // Immediate chain on R15
    runOp(4'b0011, 4'b0000, 5'd15, 5'd15, 5'd0, 1'b0, 16'd3, 1'b0);
    checkEq("lwi_3", regOut15, 16'h0003);
    runOp(4'b0001, 4'b0000, 5'd15, 5'd15, 5'd0, 1'b0, 16'd1, 1'b0);
    checkEq("andi_1", regOut15, 16'h0001);
    checkEq("andi_flags_hold", {11'b0, flagsOutput}, 16'h0000);
    runOp(4'b0101, 4'b0000, 5'd15, 5'd15, 5'd0, 1'b0, 16'd9, 1'b0);
    checkEq("addi_9", regOut15, 16'h000A);
    checkEq("addi_flags", {11'b0, flagsOutput}, 16'b01001);
    runOp(4'b1001, 4'b0000, 5'd15, 5'd15, 5'd0, 1'b0, 16'd20, 1'b0);
    checkEq("subi_20", regOut15, 16'hFFF6);
    checkEq("subi_flags", {11'b0, flagsOutput}, 16'b11001);
    runOp(4'b1011, 4'b0000, 5'd15, 5'd15, 5'd0, 1'b0, 16'hFFFB, 1'b0);
    checkEq("cmpi_m5", regOut15, 16'h0001);
    checkEq("cmpi_flags", {11'b0, flagsOutput}, 16'b11001);

    // Shifts starting at R15=1
    runOp(4'b1000, 4'b1000, 5'd15, 5'd15, 5'd0, 1'b0, 16'd2, 1'b0);
    checkEq("lshi_2", regOut15, 16'h0004);
    runOp(4'b1000, 4'b0111, 5'd15, 5'd15, 5'd0, 1'b0, 16'd1, 1'b0);
    checkEq("rshi_1", regOut15, 16'h0002);
    runOp(4'b1000, 4'b1000, 5'd15, 5'd15, 5'd0, 1'b0, 16'd14, 1'b0);
    checkEq("lshi_14", regOut15, 16'h8000);
    runOp(4'b1000, 4'b1000, 5'd15, 5'd15, 5'd0, 1'b0, 16'd1, 1'b0);
    checkEq("lshi_overflow", regOut15, 16'h0000);
    runOp(4'b0000, 4'b0000, 5'd15, 5'd15, 5'd0, 1'b0, 16'h5555, 1'b0);
    checkEq("nop_r15", regOut15, 16'h0000);
    checkEq("nop_flags_hold", {11'b0, flagsOutput}, 16'b11001);

    // Register operands and carry
    runOp(4'b0011, 4'b0000, 5'd1, 5'd0, 5'd0, 1'b0, 16'hFFFF, 1'b0);
    runOp(4'b0011, 4'b0000, 5'd2, 5'd0, 5'd0, 1'b0, 16'h0001, 1'b0);
    runOp(4'b0000, 4'b0101, 5'd15, 5'd1, 5'd2, 1'b1, 16'h0000, 1'b0);
    checkEq("add_r1_r2", regOut15, 16'h0000);
    checkEq("add_flags", {11'b0, flagsOutput}, 16'b10011);
    runOp(4'b0111, 4'b0000, 5'd15, 5'd1, 5'd2, 1'b1, 16'h0000, 1'b1);
    checkEq("addc_cin1", regOut15, 16'h0001);
    checkEq("addc_flags", {11'b0, flagsOutput}, 16'b10001);

    // ARSH and disabled write
    runOp(4'b0011, 4'b0000, 5'd15, 5'd0, 5'd0, 1'b0, 16'h8000, 1'b0);
    checkEq("lwi_8000", regOut15, 16'h8000);
    runOp(4'b1000, 4'b0011, 5'd15, 5'd15, 5'd0, 1'b0, 16'd3, 1'b0);
    checkEq("arsh_3", regOut15, 16'hF000);
    runOp(4'b0011, 4'b0000, 5'd17, 5'd0, 5'd0, 1'b0, 16'h1234, 1'b0);
    checkEq("dst17_r15", regOut15, 16'hF000);
    runOp(4'b0000, 4'b1101, 5'd15, 5'd0, 5'd1, 1'b1, 16'h0000, 1'b0);
    checkEq("dst17_r1_kept", regOut15, 16'hFFFF);
    runOp(4'b0000, 4'b0011, 5'd15, 5'd15, 5'd0, 1'b0, 16'h0F0F, 1'b0);
    checkEq("xori", regOut15, 16'hF0F0);

    // Asynchronous reset between edges, held across an attempted write
    #2;
    reset = 1'b0;
    #1;
    checkEq("areset_r15", regOut15, 16'h0000);
    checkEq("areset_flags", {11'b0, flagsOutput}, 16'h0000);
    runOp(4'b0011, 4'b0000, 5'd15, 5'd0, 5'd0, 1'b0, 16'hAAAA, 1'b0);
    checkEq("reset_blocks_write", regOut15, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    runOp(4'b0000, 4'b1101, 5'd15, 5'd0, 5'd1, 1'b1, 16'h0000, 1'b0);
    checkEq("areset_r1", regOut15, 16'h0000);
    runOp(4'b0000, 4'b1101, 5'd15, 5'd0, 5'd2, 1'b1, 16'h0000, 1'b0);
    checkEq("areset_r2", regOut15, 16'h0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
